// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register plus a word-addressed, read-only instruction
// memory with asynchronous read and two-word (instruction + immediate) decoding.
module fetch_stage #(
  parameter int          MEM_ADDR_W = 12,
  parameter string       MEM_FILE   = "instr_mem.txt",
  parameter logic [31:0] INT_VECTOR = 32'h0000_0000,
  // Words 0..3 of the image, word 0 in the low bits.
  parameter logic [63:0] PRELOAD    = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jumpBit,
  input  logic        interruptBit,
  input  logic [31:0] branchIR,
  input  logic [31:0] initPc,
  output logic [31:0] samePc,
  output logic [31:0] nextPc,
  output logic [15:0] instruction,
  output logic [15:0] immediate,
  output logic [31:0] finalInstruction
);

  localparam int DEPTH = 2 ** MEM_ADDR_W;

  logic [15:0] mem [DEPTH];
  logic [31:0] pc = 32'h0;
  logic [MEM_ADDR_W-1:0] addr;
  logic [MEM_ADDR_W-1:0] addr_next;
  logic two_word;

  // ROM image, fixed at elaboration; nothing in this block ever writes it afterwards.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 4; i++) mem[i] = PRELOAD[16*i +: 16];
  end

  // Immediate fetch wraps within the memory depth, independent of the upper PC bits.
  assign addr      = pc[MEM_ADDR_W-1:0];
  assign addr_next = addr + MEM_ADDR_W'(1);

  assign instruction      = mem[addr];
  assign two_word         = instruction[0];
  assign immediate        = two_word ? mem[addr_next] : 16'h0000;
  assign samePc           = pc;
  assign nextPc           = pc + (two_word ? 32'd2 : 32'd1);
  assign finalInstruction = {instruction, immediate};

  always_ff @(posedge clk) begin
    if (!rst)              pc <= initPc;
    else if (interruptBit) pc <= INT_VECTOR;
    else if (jumpBit)      pc <= branchIR;
    else if (!stall)       pc <= nextPc;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall, jump/interrupt
// priority and 32-bit PC wrap, checked against hand-computed values.
module tb_fetch_stage;

  localparam logic [31:0] INT_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        jumpBit = 1'b0;
  logic        interruptBit = 1'b0;
  logic [31:0] branchIR = 32'h0;
  logic [31:0] initPc = 32'h0;
  logic [31:0] samePc;
  logic [31:0] nextPc;
  logic [15:0] instruction;
  logic [15:0] immediate;
  logic [31:0] finalInstruction;

  int total = 0;
  int bad = 0;

  fetch_stage #(
    .MEM_ADDR_W (12),
    .MEM_FILE   (""),
    .INT_VECTOR (INT_VEC),
    .PRELOAD    ({16'h2000, 16'h1000, 16'h0004, 16'b0011100000010001})
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .jumpBit          (jumpBit),
    .interruptBit     (interruptBit),
    .branchIR         (branchIR),
    .initPc           (initPc),
    .samePc           (samePc),
    .nextPc           (nextPc),
    .instruction      (instruction),
    .immediate        (immediate),
    .finalInstruction (finalInstruction)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change after the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic s, input logic j, input logic irq,
                        input logic [31:0] br, input logic [31:0] ip);
    @(negedge clk);
    rst = r; stall = s; jumpBit = j; interruptBit = irq; branchIR = br; initPc = ip;
  endtask

  initial begin
    #1;
    chk("pre_pc", samePc, 32'h0);
    chk("pre_instr", {16'h0, instruction}, 32'h0000_3811);

    // 1: reset to 0, two-word instruction at PC 0
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("rst_pc", samePc, 32'h0);
    chk("rst_instr", {16'h0, instruction}, 32'h0000_3811);
    chk("rst_imm", {16'h0, immediate}, 32'h0000_0004);
    chk("rst_final", finalInstruction, 32'h3811_0004);
    chk("rst_next", nextPc, 32'd2);

    // 2: sequential fetch skips the immediate word
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("seq1_pc", samePc, 32'd2);
    chk("seq1_instr", {16'h0, instruction}, 32'h0000_1000);
    chk("seq1_imm", {16'h0, immediate}, 32'h0);
    chk("seq1_next", nextPc, 32'd3);
    chk("seq1_final", finalInstruction, 32'h1000_0000);
    tick();
    chk("seq2_pc", samePc, 32'd3);
    chk("seq2_instr", {16'h0, instruction}, 32'h0000_2000);
    chk("seq2_next", nextPc, 32'd4);

    // 3: stall holds PC 2 for three edges
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd2);
    tick();
    chk("rst2_pc", samePc, 32'd2);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_pc", samePc, 32'd2);
      chk("stall_instr", {16'h0, instruction}, 32'h0000_1000);
      chk("stall_next", nextPc, 32'd3);
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd2);
    tick();
    chk("unstall_pc", samePc, 32'd3);

    // 4: jump beats stall
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'd2);
    tick();
    chk("jmp_stall_pc", samePc, 32'h0);
    chk("jmp_stall_imm", {16'h0, immediate}, 32'h0000_0004);

    // plain jump with upper bits set: only low address bits select the word
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_5003, 32'd2);
    tick();
    chk("jmp_hi_pc", samePc, 32'h1234_5003);
    chk("jmp_hi_instr", {16'h0, instruction}, 32'h0000_2000);
    chk("jmp_hi_next", nextPc, 32'h1234_5004);

    // 5: interrupt beats jump, reset beats interrupt
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'd3, 32'd2);
    tick();
    chk("irq_pc", samePc, INT_VEC);
    chk("irq_instr", {16'h0, instruction}, 32'h0);
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'd3, 32'd2);
    tick();
    chk("rst_irq_pc", samePc, 32'd2);

    // 6: PC wraps at 2**32 from the aliased last word (single-word)
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
    tick();
    chk("wrap_pc", samePc, 32'hFFFF_FFFF);
    chk("wrap_imm", {16'h0, immediate}, 32'h0);
    chk("wrap_next", nextPc, 32'h0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
    tick();
    chk("wrap_pc_after", samePc, 32'h0);
    chk("wrap_instr_after", {16'h0, instruction}, 32'h0000_3811);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
